// File: rtl/cnu_min_sched_pkg.sv
// Shared constants and state encoding for the serial check-node min scheduler.
package cnu_min_sched_pkg;

  localparam int W       = 5;
  localparam int MAX_DEG = 24;
  localparam int IDXW    = 5;
  localparam int MAGW    = W - 1;
  localparam int LANES   = 8;
  localparam int BEATW   = IDXW - 3;

  localparam logic [MAGW-1:0] MAG_ONES = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/cnu_min_sched_if.sv
// Row-start, beat-stream and result handshake bundle of the check-node scheduler.
interface cnu_min_sched_if;
  import cnu_min_sched_pkg::*;

  logic                start;
  logic [IDXW-1:0]     deg;
  logic                in_valid;
  logic                in_ready;
  logic [LANES*W-1:0]  in_data;
  logic                out_valid;
  logic                out_ready;
  logic [MAGW-1:0]     min1;
  logic [MAGW-1:0]     min2;
  logic [IDXW-1:0]     min1_idx;
  logic                sgn_prod;
  logic                busy;

  modport master (
    output start, deg, in_valid, in_data, out_ready,
    input  in_ready, out_valid, min1, min2, min1_idx, sgn_prod, busy
  );

  modport slave (
    input  start, deg, in_valid, in_data, out_ready,
    output in_ready, out_valid, min1, min2, min1_idx, sgn_prod, busy
  );

endinterface

// File: rtl/cnu_min_sched_tree.sv
// 8-input min tree: returns smallest and second-smallest magnitude plus the lane of
// the smallest; on ties the lower lane wins.
module min_sum_tree_8 #(
  parameter int nob = 3
) (
  input  logic [8*(nob+1)-1:0] mag,
  output logic [nob:0]         cm1,
  output logic [nob:0]         cm2,
  output logic [2:0]           ci
);

  localparam int M = nob + 1;

  function automatic logic [M-1:0] min_of(input logic [M-1:0] x, input logic [M-1:0] y);
    return (y < x) ? y : x;
  endfunction

  logic [M-1:0] l1_m1 [4];
  logic [M-1:0] l1_m2 [4];
  logic [2:0]   l1_i  [4];
  logic [M-1:0] l2_m1 [2];
  logic [M-1:0] l2_m2 [2];
  logic [2:0]   l2_i  [2];
  logic         l3_take_b;

  for (genvar g = 0; g < 4; g++) begin : g_l1
    logic [M-1:0] a, b;
    assign a        = mag[(2*g)*M +: M];
    assign b        = mag[(2*g+1)*M +: M];
    assign l1_m1[g] = (b < a) ? b : a;
    assign l1_m2[g] = (b < a) ? a : b;
    assign l1_i[g]  = (b < a) ? 3'(2*g+1) : 3'(2*g);
  end

  // The right-hand pair only wins on a strict less-than, keeping the lowest lane on ties.
  for (genvar g = 0; g < 2; g++) begin : g_l2
    logic take_b;
    assign take_b   = l1_m1[2*g+1] < l1_m1[2*g];
    assign l2_m1[g] = take_b ? l1_m1[2*g+1] : l1_m1[2*g];
    assign l2_i[g]  = take_b ? l1_i[2*g+1]  : l1_i[2*g];
    assign l2_m2[g] = take_b ? min_of(l1_m1[2*g], l1_m2[2*g+1])
                             : min_of(l1_m2[2*g], l1_m1[2*g+1]);
  end

  assign l3_take_b = l2_m1[1] < l2_m1[0];
  assign cm1 = l3_take_b ? l2_m1[1] : l2_m1[0];
  assign ci  = l3_take_b ? l2_i[1]  : l2_i[0];
  assign cm2 = l3_take_b ? min_of(l2_m1[0], l2_m2[1]) : min_of(l2_m2[0], l2_m1[1]);

endmodule

// File: rtl/cnu_min_sched.sv
// Serial check-node scheduler: folds 8-lane beats of one row into running
// min1/min2/min1 index and sign parity for the layered min-sum decoder.
module cnu_min_sched
  import cnu_min_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  cnu_min_sched_if.slave  bus
);

  state_t             state, next_state;
  logic [IDXW-1:0]    deg_q;
  logic [BEATW-1:0]   last_beat;
  logic [BEATW-1:0]   beat;
  logic [MAGW-1:0]    run_min1, run_min2;
  logic [IDXW-1:0]    run_idx;
  logic               run_sgn;

  logic [IDXW-1:0]    deg_eff;
  logic               row_start;
  logic               accept;
  logic [LANES*MAGW-1:0] masked_mag;
  logic               lane_sgn;
  logic [MAGW-1:0]    cm1, cm2;
  logic [2:0]         ci;

  assign deg_eff   = (bus.deg > IDXW'(MAX_DEG)) ? IDXW'(MAX_DEG) : bus.deg;
  assign row_start = (state == IDLE) && bus.start && (bus.deg != '0);
  assign accept    = (state == ACCUM) && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (row_start) next_state = ACCUM;
      ACCUM:   if (accept && beat == last_beat) next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Lanes past the row degree must neither win the min nor flip the parity.
  always_comb begin
    masked_mag = '0;
    lane_sgn   = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if ({beat, 3'(k)} < deg_q) begin
        masked_mag[k*MAGW +: MAGW] = bus.in_data[k*W +: MAGW];
        lane_sgn = lane_sgn ^ bus.in_data[k*W + W - 1];
      end else begin
        masked_mag[k*MAGW +: MAGW] = MAG_ONES;
      end
    end
  end

  min_sum_tree_8 #(.nob(W - 2)) u_tree (
    .mag (masked_mag),
    .cm1 (cm1),
    .cm2 (cm2),
    .ci  (ci)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deg_q     <= '0;
      last_beat <= '0;
      beat      <= '0;
      run_min1  <= MAG_ONES;
      run_min2  <= MAG_ONES;
      run_idx   <= '0;
      run_sgn   <= 1'b0;
    end else if (row_start) begin
      deg_q     <= deg_eff;
      last_beat <= BEATW'((deg_eff - IDXW'(1)) >> 3);
      beat      <= '0;
      run_min1  <= MAG_ONES;
      run_min2  <= MAG_ONES;
      run_idx   <= '0;
      run_sgn   <= 1'b0;
    end else if (accept) begin
      // Strict compare so an earlier beat keeps min1 on a tie.
      if (cm1 < run_min1) begin
        run_min2 <= (cm2 < run_min1) ? cm2 : run_min1;
        run_min1 <= cm1;
        run_idx  <= {beat, ci};
      end else begin
        run_min2 <= (cm1 < run_min2) ? cm1 : run_min2;
      end
      run_sgn <= run_sgn ^ lane_sgn;
      if (beat != last_beat) beat <= beat + BEATW'(1);
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.min1      = run_min1;
  assign bus.min2      = run_min2;
  assign bus.min1_idx  = run_idx;
  assign bus.sgn_prod  = run_sgn;

endmodule

// File: doc/cnu_min_sched.md
Name: cnu_min_sched

Overview:
Serial check-node scheduler for the layered min-sum LDPC decoder. It accepts one check-node row of up to MAX_DEG variable-to-check messages, streamed in 8-lane beats. Each beat goes through one shared 8-input min tree, and the block folds the per-beat results into a running min1, min2, min1 index and sign parity. It sits between the variable-node message buffer and the check-node update/write-back stage.

Parameters:
W, 5, message width: bit W-1 is the sign, bits W-2:0 are the magnitude (sign-magnitude format).
MAX_DEG, 24, maximum row degree supported (3 beats; covers 5G BG1 degree 19).
IDXW, 5, width of the min1 index output (must satisfy 2^IDXW >= MAX_DEG).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  row-start request; sampled only in IDLE.
deg  in  IDXW  row degree for the row being started, 1..MAX_DEG.
in_valid  in  1  beat valid.
in_ready  out  1  beat accepted when in_valid && in_ready.
in_data  in  8*W  lanes 0..7; lane k holds row element beat*8+k.
out_valid  out  1  row result valid.
out_ready  in  1  downstream accepts the result.
min1  out  W-1  smallest magnitude in the row.
min2  out  W-1  second-smallest magnitude, as defined by the fold rule below.
min1_idx  out  IDXW  row position of min1.
sgn_prod  out  1  XOR of the sign bits of all valid elements.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync deassert): state = IDLE. in_ready, out_valid, busy = 0. min1 and min2 = all-ones. min1_idx = 0. sgn_prod = 0. Beat counter = 0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start with deg in 1..MAX_DEG: latch deg; nbeats = ceil(deg/8); running min1/min2 = all-ones, idx = 0, sgn = 0, beat = 0; go to ACCUM.
  - start with deg = 0: ignored, stay in IDLE.
  - start with deg > MAX_DEG: deg is clamped to MAX_DEG.
- ACCUM:
  - in_ready = 1.
  - On each accepted beat, lanes with beat*8+k >= deg are masked: magnitude forced to all-ones, sign forced to 0.
  - Masked magnitudes feed the shared tree, which returns chunk min1 (cm1), chunk min2 (cm2) and 3-bit lane index (ci) combinationally in the same cycle.
  - Fold, registered on the accepting edge:
    - If cm1 < run_min1 (strict): run_min2 = min(run_min1, cm2); run_min1 = cm1; run_idx = beat*8 + ci.
    - Else: run_min2 = min(run_min2, cm1).
    - sgn ^= XOR of the masked lane signs.
  - Ties keep the earlier index: lowest row position wins, both across beats and within the tree.
  - After the beat where beat == nbeats-1, go to DONE. Otherwise beat++.
  - in_valid low: hold all state; no timeout.
- DONE:
  - out_valid = 1; outputs are driven from the running registers and stay stable until the handshake.
  - out_valid && out_ready: go to IDLE and clear out_valid in the same edge.
  - start is ignored while not in IDLE.
- Latency: out_valid rises on the edge that accepts the last beat. With out_ready held high, a 3-beat row occupies 5 cycles (start, 3 beats, result); the next start is accepted in the cycle after the result handshake.
- min2 takes whatever cm2 the tree supplies. The fold is exact when cm2 is exact. Verification compares against a golden model that uses the same tree cm2 definition.
- Arithmetic: magnitude compares are unsigned, W-1 bits. Index = beat*8 + ci, computed as {beat, ci} truncated to IDXW.
- rst_n asserted mid-row: the row is discarded immediately and all outputs return to reset values.

Decomposition:
- Shared package/header: W, MAX_DEG, IDXW, state encodings (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2), all-ones magnitude constant.
- Sub-module: one instance of the existing 8-input min tree (min_sum_tree_8, nob = W-2), fed the masked magnitudes.
- The masking and fold logic stay in this block.

Test Plan:
- deg=8, one beat, magnitudes {9,4,7,4,12,15,6,5}, signs 0b00000101 -> min1=4, min1_idx=1, sgn_prod=0, out_valid one edge after the beat is accepted.
- deg=19, three beats, global minimum 2 at position 17 in the final beat, all others ≥3 -> min1=2, min1_idx=17; min2 matches the golden fold; lanes 3..7 of beat 2 are masked even when driven to 0.
- deg=16, equal minimum 3 at positions 5 and 12 -> min1_idx=5 (earlier wins).
- Backpressure: in_valid gaps between beats and out_ready held low for 4 cycles -> results unchanged, out_valid held, start pulses during DONE ignored.
- deg=0 start -> stays IDLE, busy=0. deg=31 -> clamped, exactly 3 beats consumed.
- rst_n pulsed low after the second beat of a 3-beat row -> outputs back to reset values immediately; a following deg=8 row completes correctly.
